// File: rtl/uart_rx_deframer_pkg.sv
// Shared types and constants for the UART receive deframer.
package uart_rx_deframer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } rx_state_e;

  localparam logic [5:0] PrescaleX8       = 6'd8;
  localparam logic [5:0] PrescaleX16      = 6'd16;
  localparam logic [5:0] PrescaleX32      = 6'd32;
  localparam logic [5:0] PrescaleDefault  = PrescaleX8;

  // Map any unsupported oversampling ratio onto the default.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PrescaleX8, PrescaleX16, PrescaleX32: return p;
      default:                              return PrescaleDefault;
    endcase
  endfunction

endpackage

// File: rtl/rx_edge_bit_cnt.sv
// Oversampling edge counter (0..prescale-1) and bit-in-frame counter.
module rx_edge_bit_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       restart_i,
  input  logic [5:0] prescale_i,
  output logic [5:0] edge_cnt_o,
  output logic [3:0] bit_cnt_o,
  output logic       bit_end_o
);

  logic [5:0] edge_q;
  logic [3:0] bit_q;

  assign bit_end_o  = en_i && (edge_q == prescale_i - 6'd1);
  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

  // Count edges within a bit and bits within a frame; a restart marks the
  // current cycle as edge 0 of a new start bit, so the next cycle is edge 1.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      edge_q <= 6'd0;
      bit_q  <= 4'd0;
    end else if (restart_i) begin
      edge_q <= 6'd1;
      bit_q  <= 4'd0;
    end else if (en_i) begin
      if (bit_end_o) begin
        edge_q <= 6'd0;
        bit_q  <= bit_q + 4'd1;
      end else begin
        edge_q <= edge_q + 6'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizer, frame FSM, 2-of-3 majority sampler,
// LSB-first shifter, parity/stop checkers and registered result strobes.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] RX_P_DATA,
  output logic                  RX_D_VLD,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int unsigned BitCntW = 4;

  logic rx_meta_q, rx_sync_q;
  rx_state_e state_q, state_d;
  logic [5:0] prescale_q;
  logic par_en_q, par_typ_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [1:0] samp_q;
  logic glitch_q, par_err_q, stp_err_q;

  logic [5:0] edge_cnt, half;
  logic [BitCntW-1:0] bit_cnt;
  logic bit_end, cnt_en, cnt_clr, restart, frame_start;
  logic samp_a, samp_b, samp_c, bit_val, par_exp, frame_ok;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign frame_start = ((state_q == StIdle) || (state_q == StDone)) && !rx_sync_q;
  assign restart     = (state_q == StDone) && !rx_sync_q;
  assign cnt_en      = state_q inside {StStart, StData, StParity, StStop};
  assign cnt_clr     = (state_q == StIdle);

  rx_edge_bit_cnt u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .restart_i  (restart),
    .prescale_i (prescale_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_end_o  (bit_end)
  );

  assign half     = {1'b0, prescale_q[5:1]};
  assign samp_a   = cnt_en && (edge_cnt == half - 6'd1);
  assign samp_b   = cnt_en && (edge_cnt == half);
  assign samp_c   = cnt_en && (edge_cnt == half + 6'd1);
  assign bit_val  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) |
                    (samp_q[1] & rx_sync_q);
  assign par_exp  = (^shift_q) ^ par_typ_q;
  assign frame_ok = !par_err_q && !stp_err_q;

  // Frame config latch, sampler and per-state bit consumers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescale_q <= PrescaleDefault;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      samp_q     <= 2'b00;
      shift_q    <= '0;
      glitch_q   <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      if (frame_start) begin
        prescale_q <= legal_prescale(PRESCALE);
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        glitch_q   <= 1'b0;
        par_err_q  <= 1'b0;
        stp_err_q  <= 1'b0;
      end
      if (samp_a) samp_q[0] <= rx_sync_q;
      if (samp_b) samp_q[1] <= rx_sync_q;
      if (samp_c) begin
        case (state_q)
          StStart:  glitch_q  <= bit_val;
          StData:   shift_q   <= {bit_val, shift_q[DATA_WIDTH-1:1]};
          StParity: par_err_q <= (bit_val != par_exp);
          StStop:   stp_err_q <= !bit_val;
          default:  ;
        endcase
      end
    end
  end

  // Result strobes are registered so data and valid appear together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RX_P_DATA <= '0;
      RX_D_VLD  <= 1'b0;
      PAR_ERR   <= 1'b0;
      STP_ERR   <= 1'b0;
    end else begin
      RX_D_VLD <= (state_q == StDone) && frame_ok;
      PAR_ERR  <= (state_q == StDone) && par_err_q;
      STP_ERR  <= (state_q == StDone) && stp_err_q;
      if ((state_q == StDone) && frame_ok) RX_P_DATA <= shift_q;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (!rx_sync_q) state_d = StStart;
      StStart:  if (bit_end) state_d = glitch_q ? StIdle : StData;
      StData:   if (bit_end && (bit_cnt == BitCntW'(DATA_WIDTH))) begin
                  state_d = par_en_q ? StParity : StStop;
                end
      StParity: if (bit_end) state_d = StStop;
      StStop:   if (bit_end) state_d = StDone;
      StDone:   state_d = rx_sync_q ? StIdle : StStart;
      default:  state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: vector table plus corner sequences.
module tb_uart_rx_deframer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN, PAR_TYP;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD, PAR_ERR, STP_ERR;

  uart_rx_deframer #(.DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PRESCALE  (PRESCALE),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monotonic strobe monitor sampled on the falling edge.
  int vld_tot = 0, perr_tot = 0, serr_tot = 0;
  int vld_cyc_last = 0, vld_cyc_prev = 0;
  logic [7:0] vld_dat_last = 8'h00, vld_dat_prev = 8'h00;
  always @(negedge CLK) begin
    if (RX_D_VLD === 1'b1) begin
      vld_tot      <= vld_tot + 1;
      vld_cyc_prev <= vld_cyc_last;
      vld_cyc_last <= cyc;
      vld_dat_prev <= vld_dat_last;
      vld_dat_last <= RX_P_DATA;
    end
    if (PAR_ERR === 1'b1) perr_tot <= perr_tot + 1;
    if (STP_ERR === 1'b1) serr_tot <= serr_tot + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; holds the line for n cycles.
  task automatic send_bit(input logic v, input int n);
    RX_IN = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Sends one frame; config inputs are scrambled mid-frame and restored
  // before the stop bit, which must not disturb the frame in flight.
  task automatic send_frame(input int bl, input logic [7:0] d, input logic pe,
                            input logic pb, input logic sb, output int st);
    logic [5:0] ps0;
    logic pe0, pt0;
    ps0 = PRESCALE; pe0 = PAR_EN; pt0 = PAR_TYP;
    st = cyc;
    send_bit(1'b0, bl);
    PRESCALE = (ps0 == 6'd8) ? 6'd32 : 6'd8;
    PAR_EN   = ~pe0;
    PAR_TYP  = ~pt0;
    for (int i = 0; i < 8; i++) send_bit(d[i], bl);
    if (pe) send_bit(pb, bl);
    PRESCALE = ps0; PAR_EN = pe0; PAR_TYP = pt0;
    send_bit(sb, bl);
    RX_IN = 1'b1;
  endtask

  typedef struct {
    logic [5:0] ps;
    int         bl;
    logic       pe, pt;
    logic [7:0] d;
    logic       pb, sb;
    int         e_vld, e_perr, e_serr;
    logic [7:0] e_dat;
  } vec_t;

  vec_t vt[8];
  int st, st2, b_vld, b_perr, b_serr;
  logic [7:0] cc;

  initial begin
    vt[0] = '{6'd8,  8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
    vt[1] = '{6'd16, 16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 0, 1, 0, 8'hA5};
    vt[2] = '{6'd32, 32, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 0, 0, 1, 8'hA5};
    vt[3] = '{6'd16, 16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
    vt[4] = '{6'd16, 16, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 0, 1, 1, 8'h3C};
    vt[5] = '{6'd8,  8,  1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1, 0, 0, 8'h07};
    vt[6] = '{6'd12, 8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1, 0, 0, 8'h5A};
    vt[7] = '{6'd32, 32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};

    RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check("reset_data", RX_P_DATA, 8'h00);
    check("reset_vld",  RX_D_VLD, 1'b0);
    check("reset_perr", PAR_ERR, 1'b0);
    check("reset_serr", STP_ERR, 1'b0);
    repeat (5) @(posedge CLK);
    #1;

    for (int v = 0; v < 8; v++) begin
      PRESCALE = vt[v].ps; PAR_EN = vt[v].pe; PAR_TYP = vt[v].pt;
      b_vld = vld_tot; b_perr = perr_tot; b_serr = serr_tot;
      send_frame(vt[v].bl, vt[v].d, vt[v].pe, vt[v].pb, vt[v].sb, st);
      repeat (20) @(posedge CLK);
      #1;
      check($sformatf("v%0d_vld_cnt", v),  vld_tot - b_vld,   vt[v].e_vld);
      check($sformatf("v%0d_perr_cnt", v), perr_tot - b_perr, vt[v].e_perr);
      check($sformatf("v%0d_serr_cnt", v), serr_tot - b_serr, vt[v].e_serr);
      check($sformatf("v%0d_data", v),     RX_P_DATA,         vt[v].e_dat);
      if (vt[v].e_vld == 1) begin
        // Two synchronizer cycles ahead of the N*PRESCALE+2 frame latency.
        check($sformatf("v%0d_latency", v), vld_cyc_last - st,
              (vt[v].pe ? 11 : 10) * vt[v].bl + 4);
      end
    end

    // Three-cycle low glitch at x16 must be discarded.
    PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    b_vld = vld_tot; b_perr = perr_tot; b_serr = serr_tot;
    send_bit(1'b0, 3);
    RX_IN = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    check("glitch_strobes", (vld_tot - b_vld) + (perr_tot - b_perr) + (serr_tot - b_serr), 0);
    b_vld = vld_tot;
    send_frame(16, 8'h96, 1'b0, 1'b0, 1'b1, st);
    repeat (20) @(posedge CLK);
    #1;
    check("glitch_next_vld", vld_tot - b_vld, 1);
    check("glitch_next_data", RX_P_DATA, 8'h96);

    // Back-to-back frames at x32 with no idle gap.
    PRESCALE = 6'd32;
    b_vld = vld_tot; b_perr = perr_tot; b_serr = serr_tot;
    send_frame(32, 8'hAA, 1'b0, 1'b0, 1'b1, st);
    send_frame(32, 8'hBB, 1'b0, 1'b0, 1'b1, st2);
    repeat (20) @(posedge CLK);
    #1;
    check("b2b_vld_cnt", vld_tot - b_vld, 2);
    check("b2b_err_cnt", (perr_tot - b_perr) + (serr_tot - b_serr), 0);
    check("b2b_gap", vld_cyc_last - vld_cyc_prev, 320);
    check("b2b_first_lat", vld_cyc_prev - st, 324);
    check("b2b_first_data", vld_dat_prev, 8'hAA);
    check("b2b_second_data", vld_dat_last, 8'hBB);

    // Reset during the data bits of 0xCC aborts the frame.
    PRESCALE = 6'd16;
    b_vld = vld_tot; b_perr = perr_tot; b_serr = serr_tot;
    cc = 8'hCC;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(cc[i], 16);
    RST = 1'b1; RX_IN = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_data", RX_P_DATA, 8'h00);
    repeat (40) @(posedge CLK);
    #1;
    check("rst_strobes", (vld_tot - b_vld) + (perr_tot - b_perr) + (serr_tot - b_serr), 0);
    check("rst_data_hold", RX_P_DATA, 8'h00);
    b_vld = vld_tot;
    send_frame(16, 8'hDD, 1'b0, 1'b0, 1'b1, st);
    repeat (20) @(posedge CLK);
    #1;
    check("rst_next_vld", vld_tot - b_vld, 1);
    check("rst_next_data", RX_P_DATA, 8'hDD);
    check("rst_next_lat", vld_cyc_last - st, 10 * 16 + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
